// File: rtl/fmt12_pkg.sv
// Shared types and constants for the 12-hour "HH:MM" display scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package fmt12_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Digit 3 is the leftmost position (hour tens), digit 0 the rightmost.
  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    EDIT_NONE     = 2'b00,
    EDIT_HOUR     = 2'b01,
    EDIT_MIN      = 2'b10,
    EDIT_NONE_ALT = 2'b11
  } edit_sel_e;

  // Active-low one-hot anode pattern for a digit position.
  function automatic logic [3:0] anode_for(digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/fmt12_display_scan_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder with blank and dash overrides.
// Blank takes priority over dash; codes above 9 decode to blank.
module seg7_decode
  import fmt12_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    if (blank) begin
      seg = SEG_BLANK;
    end else if (dash) begin
      seg = SEG_DASH;
    end else begin
      unique case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/fmt12_display_scan.sv
// Multiplexed 4-digit "HH:MM" scanner with per-frame input snapshot and PM point.
// Define FMT12_BLINK_EN to blink the field selected by edit_sel.
module fmt12_display_scan
  import fmt12_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk12,
  input  logic       reset12,
  input  logic [3:0] hour12,
  input  logic [5:0] min_bin,
  input  logic       pm,
  input  logic [1:0] edit_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int              DIV_W    = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  digit_idx_t       idx_q, idx_d;
  logic             started_q, started_d;
  logic [3:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d;
  logic             pm_q, pm_d;
  logic             tick_q, tick_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic div_wrap;
  logic snap;
  logic field_off;

  assign div_wrap = (div_q == DIV_LAST);
  // The very first wrap after reset both starts scanning and takes the first snapshot.
  assign snap     = div_wrap && (!started_q || idx_q == 2'd3);

  // Binary to BCD for the shadowed hour and minutes.
  logic [3:0] hour_disp, hour_units, min_tens, min_units;
  logic       hour_tens, hour_bad, min_bad;

  always_comb begin
    hour_bad   = (hour_q > 4'd12);
    hour_disp  = (hour_q == 4'd0) ? 4'd12 : hour_q;
    hour_tens  = (hour_disp >= 4'd10);
    hour_units = hour_tens ? (hour_disp - 4'd10) : hour_disp;

    min_bad = (min_q > 6'd59);
    if (min_q >= 6'd50) begin
      min_tens  = 4'd5;
      min_units = 4'(min_q - 6'd50);
    end else if (min_q >= 6'd40) begin
      min_tens  = 4'd4;
      min_units = 4'(min_q - 6'd40);
    end else if (min_q >= 6'd30) begin
      min_tens  = 4'd3;
      min_units = 4'(min_q - 6'd30);
    end else if (min_q >= 6'd20) begin
      min_tens  = 4'd2;
      min_units = 4'(min_q - 6'd20);
    end else if (min_q >= 6'd10) begin
      min_tens  = 4'd1;
      min_units = 4'(min_q - 6'd10);
    end else begin
      min_tens  = 4'd0;
      min_units = 4'(min_q);
    end
  end

  logic [3:0] dec_bcd;
  logic       dec_blank, dec_dash;
  logic [6:0] dec_seg;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    dec_bcd   = 4'd0;
    dec_blank = 1'b0;
    dec_dash  = 1'b0;
    unique case (idx_q)
      2'd3: begin
        dec_bcd   = {3'b000, hour_tens};
        dec_dash  = hour_bad;
        dec_blank = !hour_bad && !hour_tens;
      end
      2'd2: begin
        dec_bcd  = hour_units;
        dec_dash = hour_bad;
      end
      2'd1: begin
        dec_bcd  = min_tens;
        dec_dash = min_bad;
      end
      default: begin
        dec_bcd  = min_units;
        dec_dash = min_bad;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd   (dec_bcd),
    .blank (dec_blank),
    .dash  (dec_dash),
    .seg   (dec_seg)
  );

`ifdef FMT12_BLINK_EN
  localparam int               BCNT_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  edit_sel_e         edit_q, edit_d;

  // Frame 0 is the first snapshot; later snapshots advance the blink frame count.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    edit_d  = edit_q;
    if (snap) begin
      edit_d = edit_sel_e'(edit_sel);
      if (started_q) begin
        if (bcnt_q == BCNT_LAST) begin
          bcnt_d  = '0;
          phase_d = !phase_q;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk12 or posedge reset12) begin
    if (reset12) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      edit_q  <= EDIT_NONE;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      edit_q  <= edit_d;
    end
  end

  assign field_off = phase_q && ((edit_q == EDIT_HOUR && idx_q[1]) ||
                                 (edit_q == EDIT_MIN  && !idx_q[1]));
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_edit_sel;
  assign unused_edit_sel = ^edit_sel;
  assign field_off       = 1'b0;
`endif

  always_comb begin
    div_d     = div_wrap ? '0 : div_q + 1'b1;
    idx_d     = idx_q;
    started_d = started_q;
    hour_d    = hour_q;
    min_d     = min_q;
    pm_d      = pm_q;
    tick_d    = snap;

    if (div_wrap) begin
      started_d = 1'b1;
      if (started_q) idx_d = idx_q + 2'd1;
    end
    if (snap) begin
      hour_d = hour12;
      min_d  = min_bin;
      pm_d   = pm;
    end

    // Outputs follow the shadow one cycle after it loads; all three move together.
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (started_q) begin
      an_d  = field_off ? 4'b1111 : anode_for(idx_q);
      seg_d = dec_seg;
      dp_d  = !(idx_q == 2'd0 && pm_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk12 or posedge reset12) begin
    if (reset12) begin
      div_q     <= '0;
      idx_q     <= 2'd0;
      started_q <= 1'b0;
      hour_q    <= 4'd0;
      min_q     <= 6'd0;
      pm_q      <= 1'b0;
      tick_q    <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      started_q <= started_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      pm_q      <= pm_d;
      tick_q    <= tick_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule
